// File: rtl/seq_shift_pkg.sv
// Shared definitions for the sequential right shifter: mode codes and FSM state encoding.
package seq_shift_pkg;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/shift_step_right.sv
// Combinational single-position right shift; the inserted MSB depends on the mode.
module shift_step_right
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out
);

    logic fill;

    always_comb begin
        fill = 1'b0;
        case (mode)
            MODE_ASR: fill = in[WIDTH-1];
            MODE_ROR: fill = in[0];
            default:  fill = 1'b0;  // logical, and the unused code 2'b11
        endcase
        out = {fill, in[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_right_shifter.sv
// Iterative right shifter: one bit position per clock, result presented with a done pulse.
module seq_right_shifter
    import seq_shift_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AMT_W-1:0] shift_amt,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_out;

    shift_step_right #(
        .WIDTH(WIDTH)
    ) u_step (
        .in  (sr_q),
        .mode(mode_q),
        .out (step_out)
    );

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dout_d  = dout_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    sr_d    = data_in;
                    cnt_d   = shift_amt;
                    mode_d  = mode;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                // start is deliberately not looked at here: requests while busy are dropped
                if (cnt_q != '0) begin
                    sr_d  = step_out;
                    cnt_d = cnt_q - AMT_W'(1);
                end else begin
                    dout_d  = sr_q;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            mode_q  <= MODE_LSR;
            dout_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = dout_q;

endmodule

// File: tb/tb_seq_right_shifter.sv
// Randomized and directed checks of seq_right_shifter against an arithmetic reference model.
module tb_seq_right_shifter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data_in = '0;
    logic [1:0]   shift_amt = '0;
    logic [1:0]   mode = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] data_out;

    int total = 0;
    int bad = 0;

    seq_right_shifter #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .shift_amt(shift_amt),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] x, input int amt,
                                           input logic [1:0] m);
        int v;
        int sv;
        v = int'(x);
        if (m == 2'b01) begin
            sv = (x[W-1]) ? v - (1 << W) : v;
            return W'((sv >>> amt) & ((1 << W) - 1));
        end else if (m == 2'b10) begin
            return W'(((v >> amt) | (v << (W - amt))) & ((1 << W) - 1));
        end
        return W'(v >> amt);
    endfunction

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int amt);
        int v;
        v = int'(x);
        return W'(((v << amt) | (v >> (W - amt))) & ((1 << W) - 1));
    endfunction

    // Caller must be at a negedge. Returns the edge count (after the accept edge) at which
    // done was seen, 0 on timeout, and how many sampled cycles had busy high.
    task automatic do_op(input logic [W-1:0] d, input logic [1:0] a, input logic [1:0] m,
                         output logic [W-1:0] res, output int lat, output int nbusy);
        start = 1'b1;
        data_in = d;
        shift_amt = a;
        mode = m;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        data_in = W'($urandom);
        shift_amt = 2'($urandom);
        mode = 2'($urandom);
        lat = 0;
        nbusy = 0;
        res = '0;
        if (busy) nbusy++;
        for (int e = 1; e <= 2 * W + 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = e;
                res = data_out;
                break;
            end
            if (busy) nbusy++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++;
        if (data_out !== '0) begin bad++; $display("FAIL reset_dout got=%b want=0000", data_out); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [W-1:0] d_tab [7] = '{4'b1000, 4'b1000, 4'b0100, 4'b0001, 4'b0001, 4'b1011, 4'b1011};
        logic [1:0]   a_tab [7] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd3, 2'd0, 2'd0};
        logic [1:0]   m_tab [7] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        logic [W-1:0] e_tab [7] = '{4'b0001, 4'b1110, 4'b0001, 4'b1000, 4'b0010, 4'b1011, 4'b1011};
        logic [W-1:0] res;
        int lat, nb;
        for (int i = 0; i < 7; i++) begin
            do_op(d_tab[i], a_tab[i], m_tab[i], res, lat, nb);
            total++;
            if (res !== e_tab[i]) begin
                bad++;
                $display("FAIL dir%0d_result got=%b want=%b", i, res, e_tab[i]);
            end
            total++;
            if (lat != int'(a_tab[i]) + 1) begin
                bad++;
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, int'(a_tab[i]) + 1);
            end
            total++;
            if (nb != int'(a_tab[i]) + 1) begin
                bad++;
                $display("FAIL dir%0d_busy_cycles got=%0d want=%0d", i, nb, int'(a_tab[i]) + 1);
            end
            @(negedge clk);
        end
        // rotate right by one must match the left barrel shifter rotating by three
        do_op(4'b0110, 2'd1, 2'b10, res, lat, nb);
        total++;
        if (res !== rotl(4'b0110, 3)) begin
            bad++;
            $display("FAIL ror1_vs_rol3 got=%b want=%b", res, rotl(4'b0110, 3));
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [W-1:0] d, res, exp;
        logic [1:0] a, m;
        int lat, nb;
        for (int i = 0; i < 40; i++) begin
            d = W'($urandom);
            a = 2'($urandom);
            m = 2'($urandom);
            exp = model(d, int'(a), m);
            do_op(d, a, m, res, lat, nb);
            total++;
            if (res !== exp || lat != int'(a) + 1) begin
                bad++;
                $display("FAIL rand%0d d=%b a=%0d m=%b got=%b lat=%0d want=%b lat=%0d",
                         i, d, a, m, res, lat, exp, int'(a) + 1);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0 || data_out !== exp) begin
                bad++;
                $display("FAIL rand%0d_hold done=%b dout=%b want done=0 dout=%b",
                         i, done, data_out, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] res;
        int lat, nb;
        lat = 0;
        start = 1'b1; data_in = 4'b1111; shift_amt = 2'd3; mode = 2'b00;
        @(posedge clk);
        @(negedge clk);
        // request while busy: must be dropped
        start = 1'b1; data_in = 4'b0000; shift_amt = 2'd0; mode = 2'b01;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 2; e <= 2 * W + 4; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = e; break; end
        end
        total++;
        if (lat != 4 || data_out !== 4'b0001) begin
            bad++;
            $display("FAIL ignore_start lat=%0d dout=%b want lat=4 dout=0001", lat, data_out);
        end
        do_op(4'b1100, 2'd1, 2'b00, res, lat, nb);
        total++;
        if (res !== 4'b0110 || lat != 2) begin
            bad++;
            $display("FAIL back_to_back got=%b lat=%0d want=0110 lat=2", res, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] res;
        int lat, nb;
        bit seen;
        start = 1'b1; data_in = 4'b1111; shift_amt = 2'd3; mode = 2'b10;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== '0) begin
            bad++;
            $display("FAIL async_reset busy=%b done=%b dout=%b want 0 0 0000", busy, done, data_out);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL no_done_after_reset got activity want none"); end
        do_op(4'b1001, 2'd2, 2'b01, res, lat, nb);
        total++;
        if (res !== 4'b1110 || lat != 3) begin
            bad++;
            $display("FAIL post_reset_op got=%b lat=%0d want=1110 lat=3", res, lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_right_shifter.md
Name: seq_right_shifter

Overview:
Iterative, multi-cycle right shifter. It is the opposite-direction partner of the team's combinational 4-bit left barrel shifter.
It accepts a word, a shift amount and a mode on a start pulse, shifts right one bit position per clock, then presents the result with a one-cycle done pulse.
It is used where area matters more than latency, and as a sequential cross-check against the barrel shifter in shared benches.

Parameters:
WIDTH, 4, data word width in bits (legal range 2..32).
AMT_W, $clog2(WIDTH), width of the shift amount field.

Ports:
clk  input  1  single system clock, rising-edge active
rst  input  1  asynchronous, active-high reset
start  input  1  request to begin an operation; sampled on rising clk edge
data_in  input  WIDTH  operand, captured when start is accepted
shift_amt  input  AMT_W  number of bit positions to shift right, captured with data_in
mode  input  2  00 logical, 01 arithmetic, 10 rotate right, 11 treated as logical
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse when data_out is updated
data_out  output  WIDTH  result of the last completed operation

Behaviour:
- Reset (rst=1, asynchronous, any state):
  - state=IDLE; busy=0, done=0, data_out=0.
  - Internal shift register and counter cleared.
  - Any in-flight operation is abandoned; no done pulse is produced for it.
- States: IDLE, SHIFT, DONE. Encoding is binary, 2 bits.
- Accept rule: start is accepted on a rising edge only when busy=0, i.e. in IDLE or DONE.
  - On accept: the shift register loads data_in, the counter loads shift_amt, the mode is latched, and the next state is SHIFT.
  - start while busy=1 is ignored and has no side effects.
- SHIFT, counter != 0 (each edge):
  - Shift register moves right by one position; counter decrements.
  - MSB fill: logical inserts 0; arithmetic inserts the latched operand MSB (sign); rotate inserts the bit shifted out of bit 0.
- SHIFT, counter == 0 (next edge):
  - data_out is loaded from the shift register; the next state is DONE.
- DONE: lasts exactly one cycle with done=1.
  - Next state is IDLE, or SHIFT if start is asserted (back-to-back accept).
- busy=1 exactly when state=SHIFT. done=1 exactly when state=DONE.
- Latency: with the accept edge as edge 0, done is high in the cycle after edge shift_amt+1. That is 1 cycle for amt=0 and WIDTH cycles for amt=WIDTH-1.
- data_out holds its value between done pulses. It changes only on the transition into DONE, or on reset.
- The maximum amount is WIDTH-1. Amounts are never wrapped or saturated, since the field width already bounds them.
- Mode 11 behaves identically to mode 00.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Shared package seq_shift_pkg:
  - MODE_LSR=2'b00, MODE_ASR=2'b01, MODE_ROR=2'b10.
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
- One natural sub-module, shift_step_right: a purely combinational single-position right shift with selectable fill (WIDTH parameter; ports in, mode, out).
- The top level holds the FSM, counter and registers.

Test Plan:
- WIDTH=4, data_in=4'b1000, shift_amt=3, mode=00, start for 1 cycle -> busy high 4 cycles; done pulses in cycle 4 after accept; data_out=4'b0001.
- data_in=4'b1000, shift_amt=2, mode=01 -> data_out=4'b1110 (sign fill); data_in=4'b0100, same settings -> 4'b0001.
- data_in=4'b0001, shift_amt=1, mode=10 -> data_out=4'b1000; shift_amt=3 -> 4'b0010. Rotating right by 1 must reproduce the left barrel shifter's result for amt=3.
- data_in=4'b1011, shift_amt=0, any mode -> done in the first cycle after accept; data_out=4'b1011; busy high for exactly 1 cycle.
- Start op A (4'b1111, amt=3, mode=00); pulse start with 4'b0000 during SHIFT -> ignored; data_out=4'b0001. Assert start in the DONE cycle with 4'b1100, amt=1, mode=00 -> accepted back-to-back; next data_out=4'b0110.
- Assert rst asynchronously mid-SHIFT (between edges) -> busy, done and data_out are 0 immediately; no done pulse follows. A fresh start after reset release completes normally.
